// File: rtl/tanh_pkg.sv
// Shared definitions for the tanh core sample sequencer.
//   DATA_W          : sample / result width
//   DEFAULT_DEPTH   : default input FIFO depth
//   DEFAULT_TIMEOUT : default per-sample wait budget in cycles
//   seq_state_e     : sequencer FSM state encoding
package tanh_pkg;

  localparam int DATA_W          = 16;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tanh_in_fifo.sv
// Synchronous input FIFO for the tanh sample sequencer.
//   clk, rst     : clock, async active-low reset
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry, valid when !empty_o
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : occupancy, one bit wider than the pointers
// No bypass: an entry written at edge N is visible on head_o after edge N.
module tanh_in_fifo
  import tanh_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count_q
  // disambiguates full from empty when the pointers are equal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tanh_sample_sequencer.sv
// Streaming front end for the start/ready tanh core.
//   clk, rst              : clock, async active-low reset
//   in_data/valid/ready   : sample input stream into the FIFO
//   out_data/valid/ready  : registered result output stream
//   core_x, core_start    : operand and one-cycle start pulse to the core
//   core_ready, core_y    : core idle/done flag and its result
//   count                 : input FIFO occupancy
//   err                   : sticky timeout flag, cleared only by reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a sample, an idle core and a free output slot
// ISSUE     | core_start high for this single cycle
// WAIT_BUSY | waiting for the core to drop ready (accepted the start)
// WAIT_DONE | waiting for ready to return, then capture core_y
module tanh_sample_sequencer
  import tanh_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       core_x,
  output logic                    core_start,
  input  logic                    core_ready,
  input  logic [DATA_W-1:0]       core_y,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] core_x_q, core_x_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              tmo_last;

  tanh_in_fifo #(
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  // The cycle that would bring the counter to TIMEOUT is the expiry cycle.
  assign tmo_last = (tmo_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    core_x_d    = core_x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    start_d     = 1'b0;
    err_d       = err_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Reserving the output slot here means a later capture can never
        // overwrite an undelivered result.
        if (!fifo_empty && core_ready && (!out_valid_q || out_ready)) begin
          pop      = 1'b1;
          core_x_d = fifo_head;
          tmo_d    = '0;
          start_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tmo_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
          if (!core_ready) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion on the final allowed cycle still delivers its result.
        if (core_ready) begin
          out_data_d  = core_y;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmo_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      core_x_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      core_x_q    <= core_x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign core_x     = core_x_q;
  assign core_start = start_q;
  assign err        = err_q;

endmodule

// File: doc/tanh_sample_sequencer.md
# tanh_sample_sequencer

Upstream feeder and result capture for the tanh core. It accepts 16-bit samples over a valid/ready stream and buffers them in a small FIFO. It issues each sample to the core with a one-cycle `start` pulse, waits for the core's completion handshake, and presents `Y` on a registered valid/ready output. This lets a streaming producer drive the start/ready-style core without tracking its variable latency.

## Interface
- `DEPTH`, 4: input FIFO entries; must be a power of two, ≥2.
- `TIMEOUT`, 255: maximum cycles allowed in each wait state before the sample is abandoned.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  16  sample X, two's-complement fixed point, passed through unmodified.
- `in_valid`  in  1  producer has a sample.
- `in_ready`  out  1  FIFO not full.
- `out_data`  out  16  captured core result Y.
- `out_valid`  out  1  `out_data` holds an undelivered result.
- `out_ready`  in  1  consumer accepts.
- `core_x`  out  16  operand to the core (`X`); registered, stable from issue until capture.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_ready`  in  1  core `ready`: high when idle or done, low while computing.
- `core_y`  in  16  core `Y`.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err`  out  1  sticky timeout flag.

## Operation
- **FIFO push:** `in_valid && in_ready`. `in_ready = (count != DEPTH)`. There is no bypass: a sample pushed at edge N is poppable no earlier than edge N+1.
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - **IDLE → ISSUE:** when FIFO is non-empty, `core_ready`=1, and the output slot is free (`!out_valid || out_ready`). On that edge: pop the head into `core_x`, and clear the timeout counter.
  - **ISSUE:** `core_start`=1 for exactly this cycle, then → WAIT_BUSY.
  - **WAIT_BUSY → WAIT_DONE:** when `core_ready`=0.
  - **WAIT_DONE → IDLE:** when `core_ready`=1. On that edge: `out_data`←`core_y`, `out_valid`←1.
- **Timeout:** the counter increments each cycle in WAIT_BUSY or WAIT_DONE. When it reaches TIMEOUT: set `err`=1, drop the sample (no output), → IDLE. `err` is cleared only by reset.
- **Output drain:** `out_valid` clears on `out_ready` unless a capture occurs on the same edge, in which case it stays 1 with the new data. The output slot reservation at issue guarantees a capture never overwrites an undelivered result.
- **Simultaneous events:**
  - Push and pop on the same edge leave `count` unchanged.
  - A push when `count`=DEPTH is impossible because `in_ready`=0.
- **Pointers:** $clog2(DEPTH) bits, wrap naturally. `count` is tracked separately to distinguish full from empty.
- **Reset (any time, including mid-computation):** state→IDLE, FIFO emptied, in-flight sample discarded.
  - Output reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `core_x`=0, `core_start`=0, `count`=0, `err`=0.
  - The core shares the same reset, so no stale completion is possible.

## Timing
- With a push at edge 0, empty FIFO, idle core, and free output:
  - pop/issue at edge 1;
  - `core_start` high in cycle 1–2;
  - WAIT_BUSY entered at edge 2;
  - with `core_ready` first low at edge k and high again at edge m, `out_valid` rises at edge m+1.
- The sequencer adds 2 cycles of overhead beyond the core's own latency.
- Back-to-back issue: the next pop can occur on the edge after capture, i.e. the IDLE cycle.
- Throughput is one sample per (core latency + 3) cycles.
- `core_start` is never asserted while `core_ready`=0.

## Structure
- A shared `tanh_pkg` holds:
  - the state enum;
  - the data width constant (16);
  - the default DEPTH/TIMEOUT.
- One natural sub-module is `tanh_in_fifo`, a synchronous FIFO parameterised by DEPTH with push/pop/count.
- The FSM, timeout counter, and output register live in the top level.

## Test plan
Use a behavioural core model: `ready` drops the cycle after `start`, returns high 10 cycles later, and returns Y = ~X.
- **Single sample:** push 0x1234 → `core_start` pulses once, then `out_data`=0xEDCB with `out_valid` 13 cycles after the push; `count` returns to 0.
- **Fill:** push 5 samples 0x0001–0x0005 with `out_ready`=1 → `in_ready` drops when `count`=4; outputs 0xFFFE…0xFFFA arrive in order with no loss.
- **Output backpressure:** hold `out_ready`=0 with 2 samples queued → first result stays on `out_data`, no second issue, `core_start` stays low; release → second result follows.
- **Timeout:** the model never drops `ready` and TIMEOUT=8 → `err`=1 at 9 cycles after issue, no `out_valid`, and the next sample is processed normally.
- **Reset mid-computation:** pull `rst` low during WAIT_DONE with 3 samples queued → all outputs at reset values immediately; no output appears after release.
- **Start protection:** assert the model's `ready` low externally in IDLE → no pop or issue until it returns high.
